// File: rtl/ex_mem_stage.sv
`default_nettype none
// =====================================================================
// ex_mem_stage : EX/MEM boundary, 2-entry elastic buffer, BEQ resolve
// Optional forwarding bus enabled by defining EXMEM_FWD_EN.
// Revision 1.0
// =====================================================================
module ex_mem_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_result,
    input  logic          in_zero,
    input  logic [RW-1:0] in_rd,
    input  logic          in_regwrite,
    input  logic          in_branch,
    input  logic [DW-1:0] in_target,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic [RW-1:0] out_rd,
    output logic          out_regwrite,
    output logic          br_taken,
    output logic [DW-1:0] br_target,
    output logic [1:0]    occupancy,
    output logic          fwd_valid,
    output logic [RW-1:0] fwd_rd,
    output logic [DW-1:0] fwd_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_head;
    logic          r_tail;
    logic [DW-1:0] r_result [2];
    logic [RW-1:0] r_rd     [2];
    logic          r_rw     [2];
    logic          r_br_taken;
    logic [DW-1:0] r_br_target;
    logic          w_push;
    logic          w_pop;
    logic          w_rw;

    // in_ready is gated by rst_n so nothing is accepted while held in reset
    assign in_ready = rst_n & (r_state != FULL);
    assign w_push   = in_valid & in_ready & ~flush;
    assign w_pop    = out_valid & out_ready;
    assign w_rw     = in_regwrite & ~in_branch & (in_rd != '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            EMPTY: if (w_push) w_next = ONE;
            ONE: begin
                if (w_push && !w_pop)      w_next = FULL;
                else if (!w_push && w_pop) w_next = EMPTY;
            end
            FULL:  if (w_pop) w_next = ONE;
            default: w_next = EMPTY;
        endcase
        if (flush) w_next = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (flush) begin
                r_head <= 1'b0;
                r_tail <= 1'b0;
            end else begin
                if (w_push) r_tail <= ~r_tail;
                if (w_pop)  r_head <= ~r_head;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_result[i] <= '0;
                r_rd[i]     <= '0;
                r_rw[i]     <= 1'b0;
            end
        end else if (w_push) begin
            r_result[r_tail] <= in_result;
            r_rd[r_tail]     <= in_rd;
            r_rw[r_tail]     <= w_rw;
        end
    end

    // Branch pulse: push already excludes flush, so flushed branches never fire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
        end else begin
            r_br_taken <= w_push & in_branch & in_zero;
            if (w_push && in_branch && in_zero) r_br_target <= in_target;
        end
    end

    assign out_valid    = (r_state != EMPTY);
    assign out_result   = out_valid ? r_result[r_head] : '0;
    assign out_rd       = out_valid ? r_rd[r_head]     : '0;
    assign out_regwrite = out_valid & r_rw[r_head];
    assign occupancy    = r_state;
    assign br_taken     = r_br_taken;
    assign br_target    = r_br_target;

`ifdef EXMEM_FWD_EN
    assign fwd_valid = out_valid & out_regwrite;
    assign fwd_rd    = out_rd;
    assign fwd_data  = out_result;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// =====================================================================
// tb_ex_mem_stage : queue-model bench with directed vectors
// Revision 1.0
// =====================================================================
module tb_ex_mem_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_result = '0;
    logic          in_zero = 1'b0;
    logic [RW-1:0] in_rd = '0;
    logic          in_regwrite = 1'b0;
    logic          in_branch = 1'b0;
    logic [DW-1:0] in_target = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_result;
    logic [RW-1:0] out_rd;
    logic          out_regwrite;
    logic          br_taken;
    logic [DW-1:0] br_target;
    logic [1:0]    occupancy;
    logic          fwd_valid;
    logic [RW-1:0] fwd_rd;
    logic [DW-1:0] fwd_data;

    int n_vec = 0;
    int n_err = 0;

    ex_mem_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_zero(in_zero), .in_rd(in_rd),
        .in_regwrite(in_regwrite), .in_branch(in_branch), .in_target(in_target),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_regwrite(out_regwrite),
        .br_taken(br_taken), .br_target(br_target), .occupancy(occupancy),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [DW-1:0] result;
        logic [RW-1:0] rd;
        logic          rw;
    } ent_t;

    ent_t          mq[$];
    logic          m_br = 1'b0;
    logic [DW-1:0] m_tgt = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_br  = 1'b0;
            m_tgt = '0;
        end else begin
            automatic bit   acc  = in_valid && (mq.size() < 2) && !flush;
            automatic bit   take = mq.size() > 0 && out_ready;
            automatic ent_t e;
            e.result = in_result;
            e.rd     = in_rd;
            e.rw     = in_regwrite && !in_branch && (in_rd != 0);
            m_br = acc && in_branch && in_zero;
            if (m_br) m_tgt = in_target;
            if (flush) mq.delete();
            else begin
                if (take) void'(mq.pop_front());
                if (acc)  mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        automatic bit            v   = mq.size() != 0;
        automatic logic [DW-1:0] er  = v ? mq[0].result : '0;
        automatic logic [RW-1:0] ed  = v ? mq[0].rd : '0;
        automatic logic          ew  = v ? mq[0].rw : 1'b0;
        chk("in_ready",     32'(in_ready),     32'(rst_n && mq.size() < 2));
        chk("out_valid",    32'(out_valid),    32'(v));
        chk("out_result",   out_result,        er);
        chk("out_rd",       32'(out_rd),       32'(ed));
        chk("out_regwrite", 32'(out_regwrite), 32'(ew));
        chk("occupancy",    32'(occupancy),    32'(mq.size()));
        chk("br_taken",     32'(br_taken),     32'(m_br));
        chk("br_target",    br_target,         m_tgt);
`ifdef EXMEM_FWD_EN
        chk("fwd_valid",    32'(fwd_valid),    32'(v && ew));
        chk("fwd_rd",       32'(fwd_rd),       32'(ed));
        chk("fwd_data",     fwd_data,          er);
`else
        chk("fwd_valid",    32'(fwd_valid),    32'd0);
        chk("fwd_rd",       32'(fwd_rd),       32'd0);
        chk("fwd_data",     fwd_data,          32'd0);
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                         input logic rw, input logic br, input logic z, input logic [31:0] tgt);
        in_valid    = v;
        in_result   = res;
        in_rd       = rd;
        in_regwrite = rw;
        in_branch   = br;
        in_zero     = z;
        in_target   = tgt;
    endtask

    initial begin
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_occ",      32'(occupancy), 32'd0);
        rst_n = 1'b1;
        step();

        // single entry, straight through
        out_ready = 1'b1;
        drive(1, 32'h5, 5'd3, 1, 0, 0, 0);
        step();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_result", out_result, 32'h5);
        chk("t1_rd", 32'(out_rd), 32'd3);
        chk("t1_rw", 32'(out_regwrite), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("t1_drain", 32'(out_valid), 32'd0);

        // backpressure and ordering
        out_ready = 1'b0;
        drive(1, 32'h11, 5'd1, 1, 0, 0, 0);
        step();
        drive(1, 32'h22, 5'd2, 1, 0, 0, 0);
        step();
        chk("t2_full_occ", 32'(occupancy), 32'd2);
        chk("t2_full_rdy", 32'(in_ready), 32'd0);
        drive(1, 32'h33, 5'd4, 1, 0, 0, 0);
        step();
        chk("t2_hold", out_result, 32'h11);
        out_ready = 1'b1;
        step();
        chk("t2_pop1", out_result, 32'h22);
        chk("t2_pop1_occ", 32'(occupancy), 32'd1);
        step();
        chk("t2_third", out_result, 32'h33);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("t2_empty", 32'(occupancy), 32'd0);

        // branch taken / not taken
        drive(1, 32'h0, 5'd5, 1, 1, 1, 32'h40);
        step();
        chk("t3_taken", 32'(br_taken), 32'd1);
        chk("t3_target", br_target, 32'h40);
        chk("t3_rw", 32'(out_regwrite), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("t3_pulse_end", 32'(br_taken), 32'd0);
        chk("t3_tgt_hold", br_target, 32'h40);
        drive(1, 32'h9, 5'd5, 1, 1, 0, 32'h80);
        step();
        chk("t3_not_taken", 32'(br_taken), 32'd0);
        chk("t3_tgt_hold2", br_target, 32'h40);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();

        // flush while full, incoming branch entry dropped
        out_ready = 1'b0;
        drive(1, 32'hA1, 5'd6, 1, 0, 0, 0);
        step();
        step();
        chk("t4_full", 32'(occupancy), 32'd2);
        drive(1, 32'hDEAD, 5'd9, 1, 1, 1, 32'h100);
        flush = 1'b1;
        step();
        chk("t4_occ", 32'(occupancy), 32'd0);
        chk("t4_valid", 32'(out_valid), 32'd0);
        chk("t4_br", 32'(br_taken), 32'd0);
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        out_ready = 1'b1;
        step();
        chk("t4_stay_empty", 32'(out_valid), 32'd0);

        // r0 write suppression and forwarding
        drive(1, 32'h77, 5'd0, 1, 0, 0, 0);
        step();
        chk("t5_r0_rw", 32'(out_regwrite), 32'd0);
        drive(1, 32'hFFFF_FFFF, 5'd7, 1, 0, 0, 0);
        step();
`ifdef EXMEM_FWD_EN
        chk("t5_fwd_valid", 32'(fwd_valid), 32'd1);
        chk("t5_fwd_rd", 32'(fwd_rd), 32'd7);
        chk("t5_fwd_data", fwd_data, 32'hFFFF_FFFF);
`else
        chk("t5_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("t5_fwd_rd", 32'(fwd_rd), 32'd0);
        chk("t5_fwd_data", fwd_data, 32'd0);
`endif
        drive(0, 0, 0, 0, 0, 0, 0);
        step();

        // streaming with a fixed out_ready pattern
        for (int i = 0; i < 24; i++) begin
            out_ready = ((i % 3) != 1);
            drive(i[0] | i[2], 32'h1000 + 32'(i), 5'(i), i[1], 5'(i) == 5'd9 ? 1'b1 : 1'b0,
                  i[3], 32'h2000 + 32'(i));
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        out_ready = 1'b1;
        step();
        step();

        // async reset with one entry held and a branch pulse on the outputs
        out_ready = 1'b0;
        drive(1, 32'h55, 5'd8, 1, 1, 1, 32'h200);
        step();
        chk("t6_pre_occ", 32'(occupancy), 32'd1);
        chk("t6_pre_br", 32'(br_taken), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_br", 32'(br_taken), 32'd0);
        chk("t6_rst_tgt", br_target, 32'd0);
        chk("t6_rst_occ", 32'(occupancy), 32'd0);
        chk("t6_rst_rdy", 32'(in_ready), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("t6_post_br", 32'(br_taken), 32'd0);
        chk("t6_post_rdy", 32'(in_ready), 32'd1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
